// File: rtl/cb_config_loader.sv
// cb_config_loader
//   Streams one connection-block configuration word in DW-bit chunks,
//   assembles it into c_out, then strobes the per-tile config-set line of
//   the tile that was selected when the load started.
//
//   Optional feature: define CB_CONFIG_PARITY_EN to require one trailing
//   DW-bit parity chunk (XOR of all data chunks) before commit. On a parity
//   mismatch err is set, no cset is issued, and done still pulses.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a load (only looked at in IDLE)
//   tile_sel   in   [TW-1:0] target tile, captured with start
//   din_valid  in   chunk valid
//   din        in   [DW-1:0] chunk data
//   din_ready  out  chunk accepted this cycle when din_valid is also high
//   busy       out  any state other than IDLE
//   done       out  one-cycle completion pulse
//   err        out  sticky error (bad tile_sel, or parity mismatch)
//   c_out      out  [CONF_WIDTH-1:0] assembled configuration word
//   cset       out  [NTILES-1:0] one-hot config-set strobe
module cb_config_loader #(
  parameter int CONF_WIDTH = 128,
  parameter int DW         = 8,
  parameter int NTILES     = 4,
  localparam int TW        = (NTILES > 1) ? $clog2(NTILES) : 1,
  localparam int NW        = (CONF_WIDTH + DW - 1) / DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TW-1:0]         tile_sel,
  input  logic                  din_valid,
  input  logic [DW-1:0]         din,
  output logic                  din_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CONF_WIDTH-1:0] c_out,
  output logic [NTILES-1:0]     cset
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [TW-1:0]           tile_reg;
  logic [CW-1:0]           cnt_reg;
  logic [CONF_WIDTH-1:0]   c_reg;
  logic                    err_reg;
  logic                    tile_ok;
  logic                    last_chunk;
  logic                    load_xfer;
  logic [CONF_WIDTH-1:0]   bit_we;
  logic [CONF_WIDTH-1:0]   bit_d;

`ifdef CB_CONFIG_PARITY_EN
  logic [DW-1:0]           parity_reg;
  logic                    parity_ok;
  assign parity_ok = (din == parity_reg);
`endif

  assign tile_ok    = ({{(32-TW){1'b0}}, tile_sel} < 32'(NTILES));
  assign last_chunk = (cnt_reg == CW'(NW - 1));
  assign load_xfer  = (state_reg == LOAD) && din_valid;

  // Per-bit write enable: bit gi belongs to chunk gi/DW and takes din bit
  // gi%DW. Bits of the last chunk above CONF_WIDTH-1 simply have no home.
  generate
    for (genvar gi = 0; gi < CONF_WIDTH; gi++) begin : g_bit
      assign bit_we[gi] = load_xfer && (cnt_reg == CW'(gi / DW));
      assign bit_d[gi]  = din[gi % DW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    din_ready  = 1'b0;
    cset       = '0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && tile_ok) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid && last_chunk) begin
`ifdef CB_CONFIG_PARITY_EN
          state_next = CHECK;
`else
          state_next = COMMIT;
`endif
        end
      end
      CHECK: begin
`ifdef CB_CONFIG_PARITY_EN
        din_ready = 1'b1;
        if (din_valid) begin
          state_next = parity_ok ? COMMIT : DONE;
        end
`else
        state_next = IDLE;
`endif
      end
      COMMIT: begin
        cset       = NTILES'(1) << tile_reg;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_reg   <= '0;
      cnt_reg    <= '0;
      c_reg      <= '0;
      err_reg    <= 1'b0;
`ifdef CB_CONFIG_PARITY_EN
      parity_reg <= '0;
`endif
    end else begin
      if ((state_reg == IDLE) && start) begin
        if (tile_ok) begin
          tile_reg   <= tile_sel;
          cnt_reg    <= '0;
          c_reg      <= '0;
          err_reg    <= 1'b0;
`ifdef CB_CONFIG_PARITY_EN
          parity_reg <= '0;
`endif
        end else begin
          // Rejected start leaves c_out and the previous tile untouched.
          err_reg <= 1'b1;
        end
      end
      if (load_xfer) begin
        c_reg   <= (c_reg & ~bit_we) | (bit_d & bit_we);
        cnt_reg <= cnt_reg + 1'b1;
`ifdef CB_CONFIG_PARITY_EN
        parity_reg <= parity_reg ^ din;
`endif
      end
`ifdef CB_CONFIG_PARITY_EN
      if ((state_reg == CHECK) && din_valid && !parity_ok) begin
        err_reg <= 1'b1;
      end
`endif
    end
  end

  assign busy  = (state_reg != IDLE);
  assign err   = err_reg;
  assign c_out = c_reg;

endmodule
